// File: rtl/dma_cpu_programmer.sv
// CPU-side programmer for one channel of an 8237-style DMA controller.
// Replays a fixed register-write sequence over a slave I/O bus with timed strobes.
module dma_cpu_programmer #(
  parameter int STROBECYCLES = 2,
  parameter int DATAWIDTH    = 8,
  parameter int ADDRESSWIDTH = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    start,
  input  logic [1:0]              channel,
  input  logic [DATAWIDTH-1:0]    commandByte,
  input  logic [5:0]              modeBits,
  input  logic [ADDRESSWIDTH-1:0] baseAddress,
  input  logic [ADDRESSWIDTH-1:0] baseWordCount,
  input  logic                    readStatus,
  input  logic                    HLDA,
  output logic                    busy,
  output logic                    done,
  output logic [DATAWIDTH-1:0]    statusByte,
  output logic                    CS_N,
  output logic                    IOR_N,
  output logic                    IOW_N,
  output logic                    A3,
  output logic                    A2,
  output logic                    A1,
  output logic                    A0,
  inout  wire  [DATAWIDTH-1:0]    DB
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_SETUP,
    S_STROBE,
    S_RECOVER,
    S_DONE
  } state_t;

  localparam logic [3:0] STROBE_LAST = 4'(STROBECYCLES - 1);

  state_t                 state;
  logic [2:0]             acc_cnt;
  logic [3:0]             strobe_cnt;

  logic [1:0]             lat_channel;
  logic [DATAWIDTH-1:0]   lat_command;
  logic [5:0]             lat_mode;
  logic [15:0]            lat_addr;
  logic [15:0]            lat_count;
  logic                   lat_read_status;

  logic [3:0]             a_reg;
  logic                   db_drive;
  logic [DATAWIDTH-1:0]   db_out;

  logic                   acc_read;
  logic [3:0]             acc_addr;
  logic [DATAWIDTH-1:0]   acc_data;
  logic [2:0]             last_acc;

  assign {A3, A2, A1, A0} = a_reg;
  assign DB = db_drive ? db_out : {DATAWIDTH{1'bz}};
  assign last_acc = lat_read_status ? 3'd7 : 3'd6;

  // Register address, direction and write data of the access selected by acc_cnt.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    acc_read = 1'b0;
    acc_addr = 4'b0000;
    acc_data = '0;
    case (acc_cnt)
      3'd0: acc_addr = 4'b1100;
      3'd1: begin
        acc_addr = 4'b1000;
        acc_data = lat_command;
      end
      3'd2: begin
        acc_addr = 4'b1011;
        acc_data = DATAWIDTH'({lat_mode, lat_channel});
      end
      3'd3: begin
        acc_addr = {1'b0, lat_channel, 1'b0};
        acc_data = DATAWIDTH'(lat_addr[7:0]);
      end
      3'd4: begin
        acc_addr = {1'b0, lat_channel, 1'b0};
        acc_data = DATAWIDTH'(lat_addr[15:8]);
      end
      3'd5: begin
        acc_addr = {1'b0, lat_channel, 1'b1};
        acc_data = DATAWIDTH'(lat_count[7:0]);
      end
      3'd6: begin
        acc_addr = {1'b0, lat_channel, 1'b1};
        acc_data = DATAWIDTH'(lat_count[15:8]);
      end
      default: begin
        acc_read = 1'b1;
        acc_addr = 4'b1000;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state           <= S_IDLE;
      acc_cnt         <= '0;
      strobe_cnt      <= '0;
      lat_channel     <= '0;
      lat_command     <= '0;
      lat_mode        <= '0;
      lat_addr        <= '0;
      lat_count       <= '0;
      lat_read_status <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      statusByte      <= '0;
      CS_N            <= 1'b1;
      IOR_N           <= 1'b1;
      IOW_N           <= 1'b1;
      a_reg           <= 4'b0000;
      db_drive        <= 1'b0;
      db_out          <= '0;
    end else begin
      // NOTE: non-blocking assignments so every branch sees pre-edge values of all state.
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
          if (start) begin
            lat_channel     <= channel;
            lat_command     <= commandByte;
            lat_mode        <= modeBits;
            lat_addr        <= 16'(baseAddress);
            lat_count       <= 16'(baseWordCount);
            lat_read_status <= readStatus;
            acc_cnt         <= '0;
            busy            <= 1'b1;
            state           <= S_GAP;
          end
        end

        // The bus is only claimed here, so HLDA never cuts an access short.
        S_GAP: begin
          if (!HLDA) begin
            state    <= S_SETUP;
            CS_N     <= 1'b0;
            a_reg    <= acc_addr;
            db_drive <= !acc_read;
            db_out   <= acc_data;
          end
        end

        S_SETUP: begin
          state      <= S_STROBE;
          strobe_cnt <= STROBE_LAST;
          IOR_N      <= !acc_read;
          IOW_N      <= acc_read;
        end

        S_STROBE: begin
          if (strobe_cnt == 4'd0) begin
            state <= S_RECOVER;
            IOR_N <= 1'b1;
            IOW_N <= 1'b1;
            if (acc_read) statusByte <= DB;
          end else begin
            strobe_cnt <= strobe_cnt - 4'd1;
          end
        end

        S_RECOVER: begin
          CS_N     <= 1'b1;
          a_reg    <= 4'b0000;
          db_drive <= 1'b0;
          if (acc_cnt == last_acc) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            acc_cnt <= acc_cnt + 3'd1;
            state   <= S_GAP;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_cpu_programmer.sv
// Self-checking bench for dma_cpu_programmer: directed scenarios plus random requests,
// with a bus monitor compared against an access-list model of the programming sequence.
module tb_dma_cpu_programmer;

  localparam int SC = 2;
  localparam int DW = 8;
  localparam int AW = 16;

  typedef struct {
    logic [1:0]  ch;
    logic [7:0]  cmd;
    logic [5:0]  mode;
    logic [15:0] ba;
    logic [15:0] wc;
    logic        rs;
  } req_t;

  typedef struct {
    logic       rd;
    logic [3:0] a;
    logic [7:0] d;
  } acc_t;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    channel = '0;
  logic [DW-1:0] commandByte = '0;
  logic [5:0]    modeBits = '0;
  logic [AW-1:0] baseAddress = '0;
  logic [AW-1:0] baseWordCount = '0;
  logic          readStatus = 1'b0;
  logic          HLDA = 1'b0;
  logic          busy, done;
  logic [DW-1:0] statusByte;
  logic          CS_N, IOR_N, IOW_N, A3, A2, A1, A0;
  wire  [DW-1:0] DB;
  logic [DW-1:0] resp_val = '0;

  int errors = 0;
  int checks = 0;

  acc_t exp_q[$];
  acc_t obs_q[$];
  acc_t last_obs;

  int   cyc = 0;
  int   busy_start = 0;
  int   done_cyc = 0;
  int   done_cnt = 0;
  logic busy_q = 1'b0;
  logic strobe_q = 1'b0;
  int   strobe_len = 0;

  dma_cpu_programmer #(
    .STROBECYCLES(SC),
    .DATAWIDTH(DW),
    .ADDRESSWIDTH(AW)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .start(start),
    .channel(channel),
    .commandByte(commandByte),
    .modeBits(modeBits),
    .baseAddress(baseAddress),
    .baseWordCount(baseWordCount),
    .readStatus(readStatus),
    .HLDA(HLDA),
    .busy(busy),
    .done(done),
    .statusByte(statusByte),
    .CS_N(CS_N),
    .IOR_N(IOR_N),
    .IOW_N(IOW_N),
    .A3(A3),
    .A2(A2),
    .A1(A1),
    .A0(A0),
    .DB(DB)
  );

  // Slave register file answers reads only while selected and read-strobed.
  assign DB = (!IOR_N && !CS_N) ? resp_val : {DW{1'bz}};

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Model: the ordered list of bus accesses a request must produce.
  task automatic build_expected(input req_t r, input logic [7:0] stat);
    exp_q.push_back('{rd: 1'b0, a: 4'b1100, d: 8'h00});
    exp_q.push_back('{rd: 1'b0, a: 4'b1000, d: r.cmd});
    exp_q.push_back('{rd: 1'b0, a: 4'b1011, d: {r.mode, r.ch}});
    exp_q.push_back('{rd: 1'b0, a: {1'b0, r.ch, 1'b0}, d: r.ba[7:0]});
    exp_q.push_back('{rd: 1'b0, a: {1'b0, r.ch, 1'b0}, d: r.ba[15:8]});
    exp_q.push_back('{rd: 1'b0, a: {1'b0, r.ch, 1'b1}, d: r.wc[7:0]});
    exp_q.push_back('{rd: 1'b0, a: {1'b0, r.ch, 1'b1}, d: r.wc[15:8]});
    if (r.rs) exp_q.push_back('{rd: 1'b1, a: 4'b1000, d: stat});
  endtask

  function automatic req_t rand_req(input logic rs);
    req_t r;
    r.ch   = 2'($urandom);
    r.cmd  = 8'($urandom);
    r.mode = 6'($urandom);
    r.ba   = 16'($urandom);
    r.wc   = 16'($urandom);
    r.rs   = rs;
    return r;
  endfunction

  task automatic apply(input req_t r);
    channel       = r.ch;
    commandByte   = r.cmd;
    modeBits      = r.mode;
    baseAddress   = r.ba;
    baseWordCount = r.wc;
    readStatus    = r.rs;
  endtask

  task automatic scramble();
    apply(rand_req(1'($urandom)));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cs_n"}, CS_N, 1);
    check({tag, "_ior_n"}, IOR_N, 1);
    check({tag, "_iow_n"}, IOW_N, 1);
    check({tag, "_addr"}, {A3, A2, A1, A0}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic pulse_start(input req_t r, input string tag);
    apply(r);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int target;
    int n;
    target = done_cnt + 1;
    n = 0;
    while (done_cnt < target && n < 500) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check({tag, "_done_seen"}, (done_cnt >= target), 1);
    check({tag, "_done_not_busy"}, {done, busy}, 2'b10);
  endtask

  task automatic wait_obs(input int count, input string tag);
    int n;
    n = 0;
    while (obs_q.size() < count && n < 500) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check({tag, "_reached_access"}, obs_q.size(), count);
  endtask

  task automatic compare_accesses(input string tag);
    check({tag, "_access_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s_acc%0d", tag, i),
            {obs_q[i].rd, obs_q[i].a, obs_q[i].d},
            {exp_q[i].rd, exp_q[i].a, exp_q[i].d});
    end
  endtask

  // One programming sequence with a one-cycle start pulse; request inputs are
  // disturbed right after the latch edge to prove they were captured.
  task automatic run_req(input req_t r, input logic [7:0] stat, input string tag);
    exp_q.delete();
    obs_q.delete();
    build_expected(r, stat);
    resp_val = stat;
    pulse_start(r, tag);
    scramble();
    wait_done(tag);
    check({tag, "_latency"}, done_cyc - busy_start, r.rs ? 40 : 35);
    compare_accesses(tag);
    if (r.rs) check({tag, "_status"}, statusByte, stat);
    @(posedge CLK);
    #1;
    check({tag, "_done_one_clk"}, done, 0);
  endtask

  // Bus monitor: records each access at the first strobe clock and checks strobe rules.
  always @(negedge CLK) begin
    cyc++;
    if (RESET) begin
      strobe_q = 1'b0;
      busy_q   = busy;
    end else begin
      if (busy && !busy_q) busy_start = cyc;
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
      end
      busy_q = busy;
      check("no_strobe_overlap", (!IOR_N && !IOW_N), 0);
      if (!IOR_N || !IOW_N) begin
        check("cs_during_strobe", CS_N, 0);
        if (!strobe_q) begin
          obs_q.push_back('{rd: !IOR_N, a: {A3, A2, A1, A0}, d: DB});
          strobe_len = 1;
        end else begin
          strobe_len++;
          last_obs = obs_q[obs_q.size()-1];
          check("addr_held", {A3, A2, A1, A0}, last_obs.a);
          check("bus_data_held", DB, last_obs.d);
        end
      end else if (strobe_q) begin
        check("strobe_width", strobe_len, SC);
      end
      strobe_q = !IOR_N || !IOW_N;
    end
  end

  initial begin
    req_t r;
    logic [7:0] stat;

    repeat (3) @(posedge CLK);
    #1;
    check_idle("reset");
    check("reset_status", statusByte, 0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    check_idle("post_reset");

    // Reference request without and with the status read.
    r = '{ch: 2'd2, cmd: 8'h04, mode: 6'h12, ba: 16'h3C80, wc: 16'h0010, rs: 1'b0};
    run_req(r, 8'h00, "ref");
    check("ref_mode_byte", obs_q[2].d, 8'h4A);
    check("ref_addr_lo", {obs_q[3].a, obs_q[3].d}, 12'h480);
    r.rs = 1'b1;
    run_req(r, 8'h21, "ref_status");

    // HLDA raised during the 3rd access strobe for 20 clocks.
    r = rand_req(1'b0);
    exp_q.delete();
    obs_q.delete();
    build_expected(r, 8'h00);
    pulse_start(r, "hlda");
    wait_obs(3, "hlda");
    HLDA = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    check("hlda_stalled_count", obs_q.size(), 3);
    check("hlda_stalled_cs", CS_N, 1);
    HLDA = 1'b0;
    wait_done("hlda");
    check("hlda_latency", done_cyc - busy_start, 52);
    compare_accesses("hlda");
    check("hlda_status_hold", statusByte, 8'h21);

    // Asynchronous reset in the middle of the 5th access.
    r = rand_req(1'b0);
    exp_q.delete();
    obs_q.delete();
    pulse_start(r, "mid_reset");
    wait_obs(5, "mid_reset");
    #1;
    RESET = 1'b1;
    #1;
    check_idle("async_reset");
    check("async_reset_status", statusByte, 0);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    RESET = 1'b0;
    run_req(r, 8'h00, "replay");

    // Random requests, with and without the status read.
    for (int i = 0; i < 6; i++) begin
      r = rand_req(1'($urandom));
      stat = 8'($urandom);
      run_req(r, stat, $sformatf("rand%0d", i));
    end

    // start held high: one sequence per busy period, next begins right after done.
    r = rand_req(1'b0);
    exp_q.delete();
    obs_q.delete();
    build_expected(r, 8'h00);
    build_expected(r, 8'h00);
    apply(r);
    start = 1'b1;
    @(posedge CLK);
    #1;
    check("held_busy_rise", busy, 1);
    wait_done("held_first");
    check("held_first_latency", done_cyc - busy_start, 35);
    check("held_first_count", obs_q.size(), 7);
    @(posedge CLK);
    #1;
    check("held_restart", busy, 1);
    start = 1'b0;
    wait_done("held_second");
    check("held_second_latency", done_cyc - busy_start, 35);
    compare_accesses("held");
    repeat (5) @(posedge CLK);
    #1;
    check("held_no_third", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
